fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries, a power of 2 with 2 <= DEPTH <= 8.
REQ-002 SHALL have parameter MAX_OUTST, default 2: maximum instruction-memory requests in flight.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_req  output  1  fetch request valid.
REQ-006 Port imem_addr  output  8  byte address of the fetch.
REQ-007 Port imem_gnt  input  1  the memory accepts the request this cycle.
REQ-008 Port imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-009 Port imem_rdata  input  32  response instruction word.
REQ-010 Port stall  input  1  the consumer (IF/ID register) holds and does not take an instruction.
REQ-011 Port flush  input  1  redirect, from a taken branch or jump.
REQ-012 Port redirect_pc  input  8  new fetch address, sampled when flush=1.
REQ-013 Port instr_valid  output  1  instr_code and PC_count hold a valid instruction.
REQ-014 Port instr_code  output  32  head instruction; NOP 0x00000013 when instr_valid=0.
REQ-015 Port PC_count  output  8  address of the head instruction; 0x00 when instr_valid=0.

Function
REQ-016 An instruction SHALL be consumed on any cycle where instr_valid=1 and stall=0.
REQ-017 imem_req SHALL be 1 only when all of the following hold:
- state is RUN;
- flush=0;
- queue_count + outstanding < DEPTH;
- outstanding < MAX_OUTST.
REQ-018 A request SHALL complete on imem_req and imem_gnt both 1.
- outstanding is incremented;
- fetch_pc advances by 4, wrapping modulo 256 (0xFC -> 0x00).
REQ-019 imem_addr SHALL equal fetch_pc at all times.
REQ-020 In RUN, a response (imem_rvalid=1) SHALL be written to the queue tail with its PC and SHALL decrement outstanding.
REQ-021 A response and a consume SHALL be allowed in the same cycle; queue_count is then unchanged.
REQ-022 Without bypass, a response SHALL reach instr_valid no earlier than the next cycle.
REQ-023 A response arriving while the queue is full is impossible by the credit rule; an assertion SHALL flag it.
REQ-024 The state machine SHALL have two states, RUN and DRAIN.
REQ-025 On flush=1, from either state:
- the queue is emptied and instr_valid=0 on the next cycle;
- fetch_pc <= redirect_pc;
- discard_cnt <= outstanding - imem_rvalid;
- outstanding <= discard_cnt;
- next state is DRAIN if that count is nonzero, otherwise RUN.
REQ-026 In DRAIN, each response SHALL be dropped and SHALL decrement discard_cnt and outstanding; no requests are issued.
REQ-027 DRAIN SHALL return to RUN on the cycle discard_cnt reaches 0.
REQ-028 flush SHALL take priority over stall, consume and response in the same cycle.
REQ-029 While stall=1 and the queue is full, the outputs SHALL hold unchanged and imem_req=0.

Reset
REQ-030 While reset=1:
- imem_req=0;
- instr_valid=0, instr_code=0x00000013, PC_count=0x00;
- fetch_pc=0x00, queue, outstanding and discard_cnt cleared;
- state=RUN.
REQ-031 The first request SHALL be imem_addr=0x00 on the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL abandon in-flight responses.
- The environment guarantees no stale rvalid after reset.

Configuration
REQ-033 The macro FETCHQ_BYPASS_EN SHALL control a same-cycle bypass path.
- When defined, a RUN-state response arriving at an empty queue appears combinationally on instr_* that cycle.
- If that response is also consumed that cycle, it is not written to the queue.
- When undefined, every instruction passes through queue storage (REQ-022).

Structure
REQ-034 The shared structs package SHALL hold:
- typedef fetch_entry_t {pc[7:0], instr[31:0]};
- constants NOP_INSTR=32'h00000013 and PC_STEP=8'd4;
- the enum fetchq_state_t {RUN, DRAIN}.
REQ-035 The storage SHALL be a sub-module fetch_fifo (DEPTH entries of fetch_entry_t, with push/pop/count and simultaneous push+pop).

Verification
REQ-036 Reset release with gnt=1 and 1-cycle rvalid -> addresses 0x00, 0x04, 0x08...; first instr_valid=1 carries PC_count=0x00 (cycle 3 without bypass).
REQ-037 stall=1 for 10 cycles -> exactly 4 entries fill, imem_req drops to 0, and the head is held with PC_count unchanged.
REQ-038 flush with redirect_pc=0x40 and 2 outstanding -> DRAIN; both responses are dropped, the next request is 0x40, and the first valid PC_count is 0x40.
REQ-039 flush in the same cycle as rvalid, with 1 outstanding -> that response is dropped, the FSM goes straight to RUN, and there is no DRAIN.
REQ-040 fetch_pc=0xFC -> the next imem_addr is 0x00.
REQ-041 With FETCHQ_BYPASS_EN defined and the queue empty, an rvalid cycle gives instr_valid=1 in that same cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [7:0]  PC_STEP   = 8'd4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetchq_state_t;

    // Sequential fetch address; wraps naturally at 8 bits.
    function automatic logic [7:0] pc_next(input logic [7:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, clear and simultaneous push+pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 8'h00, instr: NOP_INSTR};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue_chk.sv
// Assertion checker for the fetch queue credit and response invariants.
module fetch_queue_chk (
    input logic clk,
    input logic reset,
    input logic rsp_run,
    input logic queue_full,
    input logic rvalid,
    input logic outst_zero
);

    // Credits reserve a slot for every request in flight, so a full queue never sees a response.
    a_no_rsp_when_full: assert property (@(posedge clk) disable iff (reset) !(rsp_run && queue_full));

    a_no_unsolicited_rsp: assert property (@(posedge clk) disable iff (reset) !(rvalid && outst_zero));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues credited imem requests, buffers responses, drains on redirect.
// Optional same-cycle response bypass when FETCHQ_BYPASS_EN is defined.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_code,
    output logic [7:0]  PC_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;

    fetchq_state_t  state_r;
    logic [7:0]     fetch_pc_r;
    logic [7:0]     rsp_pc_r;
    logic [OW-1:0]  outst_r;
    logic [OW-1:0]  discard_r;

    logic           run_s;
    logic           req_s;
    logic           grant_s;
    logic           rsp_run_s;
    logic           bypass_s;
    logic           consume_s;
    logic           push_s;
    logic           pop_s;
    logic [7:0]     credit_s;
    logic [OW-1:0]  drop_cnt_s;
    logic [OW-1:0]  outst_nxt_s;

    fetch_entry_t   push_data_s;
    fetch_entry_t   fifo_head_s;
    logic [CW-1:0]  fifo_count_s;
    logic           fifo_empty_s;
    logic           fifo_full_s;

    assign run_s       = (state_r == RUN);
    assign grant_s     = req_s && imem_gnt;
    assign rsp_run_s   = !reset && run_s && imem_rvalid && !flush;
    assign drop_cnt_s  = outst_r - OW'(imem_rvalid);
    assign outst_nxt_s = outst_r + OW'(grant_s) - OW'(imem_rvalid);
    assign consume_s   = instr_valid && !stall && !flush;
    assign push_s      = rsp_run_s && !(bypass_s && consume_s);
    assign pop_s       = consume_s && !fifo_empty_s;
    assign push_data_s = '{pc: rsp_pc_r, instr: imem_rdata};
    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_r;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_s = rsp_run_s && fifo_empty_s;
`else
    assign bypass_s = 1'b0;
`endif

    // Request gating: queued plus in-flight entries must fit in the queue.
    always_comb begin
        credit_s = 8'(fifo_count_s) + 8'(outst_r);
        if (!reset && run_s && !flush && (credit_s < 8'(DEPTH)) && (outst_r < OW'(MAX_OUTST))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Head presentation: bypassed response, else queue head, else NOP.
    always_comb begin
        if (reset) begin
            instr_valid = 1'b0;
            instr_code  = NOP_INSTR;
            PC_count    = 8'h00;
        end else if (bypass_s) begin
            instr_valid = 1'b1;
            instr_code  = imem_rdata;
            PC_count    = rsp_pc_r;
        end else if (!fifo_empty_s) begin
            instr_valid = 1'b1;
            instr_code  = fifo_head_s.instr;
            PC_count    = fifo_head_s.pc;
        end else begin
            instr_valid = 1'b0;
            instr_code  = NOP_INSTR;
            PC_count    = 8'h00;
        end
    end

    // Fetch control FSM; rsp_pc_r tracks the PC of the oldest live response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RUN;
            fetch_pc_r <= 8'h00;
            rsp_pc_r   <= 8'h00;
            outst_r    <= OW'(0);
            discard_r  <= OW'(0);
        end else if (flush) begin
            fetch_pc_r <= redirect_pc;
            rsp_pc_r   <= redirect_pc;
            outst_r    <= drop_cnt_s;
            discard_r  <= drop_cnt_s;
            state_r    <= (drop_cnt_s != OW'(0)) ? DRAIN : RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (grant_s) begin
                        fetch_pc_r <= pc_next(fetch_pc_r);
                    end
                    if (imem_rvalid) begin
                        rsp_pc_r <= pc_next(rsp_pc_r);
                    end
                    outst_r <= outst_nxt_s;
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        outst_r   <= drop_cnt_s;
                        discard_r <= discard_r - OW'(1);
                        if (discard_r == OW'(1)) begin
                            state_r <= RUN;
                        end
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    fetch_queue_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .rsp_run    (rsp_run_s),
        .queue_full (fifo_full_s),
        .rvalid     (imem_rvalid),
        .outst_zero (outst_r == OW'(0))
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model, scoreboard, directed tables and sequences.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_code;
    logic [7:0]  PC_count;

    fetch_queue #(.DEPTH(4), .MAX_OUTST(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_code  (instr_code),
        .PC_count    (PC_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       killed;
    } pend_t;

    typedef struct {
        logic       gnt;
        logic       stall;
        logic       exp_req;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
    } vec_t;

    pend_t      pend[$];
    logic [7:0] sb[$];
    logic [7:0] grant_log[$];
    logic [7:0] exp_fetch;
    int         n_tests = 0;
    int         n_fail  = 0;
    vec_t       tbl[6];

    function automatic logic [31:0] data_of(input logic [7:0] a);
        return {8'hA5, a, ~a, 8'h3C};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cycle(input logic st, input logic gn, input logic fl, input logic [7:0] rpc, input logic men);
        pend_t      p;
        logic       rsp;
        logic [7:0] e;
        @(negedge clk);
        stall = st; imem_gnt = gn; flush = fl; redirect_pc = rpc;
        rsp = men && (pend.size() > 0);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? data_of(pend[0].addr) : 32'h0000_0000;
        #1;
        if (rsp) begin
            p = pend.pop_front();
            if (!p.killed && !fl) sb.push_back(p.addr);
        end
        if (instr_valid && !st && !fl) begin
            if (sb.size() == 0) begin
                chk("consume_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("consume_pc", 32'(PC_count), 32'(e));
                chk("consume_code", instr_code, data_of(e));
            end
        end
        if (!instr_valid) begin
            chk("idle_code", instr_code, 32'h0000_0013);
            chk("idle_pc", 32'(PC_count), 32'h0);
        end
        if (fl) chk("req_during_flush", 32'(imem_req), 32'h0);
        if (imem_req && gn) begin
            chk("fetch_addr", 32'(imem_addr), 32'(exp_fetch));
            grant_log.push_back(imem_addr);
            p.addr = imem_addr; p.killed = 1'b0;
            pend.push_back(p);
            exp_fetch = exp_fetch + 8'd4;
        end
        if (fl) begin
            foreach (pend[i]) pend[i].killed = 1'b1;
            sb.delete();
            exp_fetch = rpc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; imem_gnt = 1'b0; flush = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; redirect_pc = 8'h00;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_code", instr_code, 32'h0000_0013);
        chk("rst_pc", 32'(PC_count), 32'h0);
        pend.delete(); sb.delete(); exp_fetch = 8'h00;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // reset-release stream with gnt=1 and 1-cycle responses
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
`ifdef FETCHQ_BYPASS_EN
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 8'h04};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 8'h08};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 8'h0C};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 8'h10};
`else
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 8'h04};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 8'h08};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 8'h0C};
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].stall, tbl[i].gnt, 1'b0, 8'h00, 1'b1);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_pc", i), 32'(PC_count), 32'(tbl[i].exp_pc));
        end

        // stall for 10 cycles: queue fills, requests stop, head held
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
            chk("stall_valid", 32'(instr_valid), 32'h1);
            if (sb.size() > 0) chk("stall_head_pc", 32'(PC_count), 32'(sb[0]));
        end
        chk("stall_fill", 32'(sb.size()), 32'd4);
        chk("stall_inflight", 32'(pend.size()), 32'd0);
        chk("stall_req", 32'(imem_req), 32'h0);

        // drain with silent memory so two requests stay in flight
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("outst_cap", 32'(pend.size()), 32'd2);
        chk("req_at_cap", 32'(imem_req), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("drain1_valid", 32'(instr_valid), 32'h0);
        chk("drain1_req", 32'(imem_req), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("drain2_req", 32'(imem_req), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("redirect_req", 32'(imem_req), 32'h1);
        chk("redirect_addr", 32'(imem_addr), 32'h40);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
            if (instr_valid) begin
                found = 1'b1;
                chk("redirect_first_pc", 32'(PC_count), 32'h40);
            end
        end
        chk("redirect_valid_seen", 32'(found), 32'h1);

        // flush coinciding with the only outstanding response: no DRAIN
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("one_outst", 32'(pend.size()), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 8'h80, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("nodrain_req", 32'(imem_req), 32'h1);
        chk("nodrain_addr", 32'(imem_addr), 32'h80);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

        // constrained-random traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, 8'($urandom_range(0, 63) << 2),
                  $urandom_range(0, 2) != 0);
        end

        // reset in the middle of traffic abandons in-flight work
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_rst_req", 32'(imem_req), 32'h1);
        chk("post_rst_addr", 32'(imem_addr), 32'h00);

        // address wrap 0xFC -> 0x00
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hF8, 1'b1);
        grant_log.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        found = 1'b0;
        for (int i = 0; i + 1 < grant_log.size(); i++) begin
            if (grant_log[i] == 8'hFC && !found) begin
                found = 1'b1;
                chk("wrap_addr", 32'(grant_log[i + 1]), 32'h00);
            end
        end
        chk("wrap_seen", 32'(found), 32'h1);

        // idle drain: everything delivered gets consumed
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_pend_empty", 32'(pend.size()), 32'd0);
        chk("final_valid", 32'(instr_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
